// File: rtl/inst_sequencer.sv
// Descriptor-driven instruction sequencer: walks a table of strided
// address descriptors and issues each instruction via a flag handshake.
module inst_sequencer #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 16,
    parameter int CNT_BITS    = 10,
    parameter int NUM_DESC    = 16,
    parameter int IDLE_OPCODE = 0,
    localparam int IDX_BITS   = $clog2(NUM_DESC),
    localparam int DESC_BITS  = OPCODE_BITS + 4*ADDR_BITS + CNT_BITS + 2,
    localparam int INST_BITS  = OPCODE_BITS + 2*ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 desc_wr_en,
    input  logic [IDX_BITS-1:0]  desc_wr_idx,
    input  logic [DESC_BITS-1:0] desc_wr_data,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 flag,
    input  logic                 idle_flag,
    output logic [INST_BITS-1:0] instruction,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [IDX_BITS-1:0]  cur_desc,
    output logic [31:0]          issued_cnt
);

    localparam int OFF_CNT = 2;
    localparam int OFF_BS  = OFF_CNT + CNT_BITS;
    localparam int OFF_BB  = OFF_BS + ADDR_BITS;
    localparam int OFF_AS  = OFF_BB + ADDR_BITS;
    localparam int OFF_AB  = OFF_AS + ADDR_BITS;
    localparam int OFF_OP  = OFF_AB + ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_ACK,
        S_SYNC,
        S_DRAIN_ISSUE,
        S_DRAIN_ACK,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DESC_BITS-1:0]   r_table [NUM_DESC];
    logic                   r_flag_q;
    logic [IDX_BITS-1:0]    r_cur_desc;
    logic [31:0]            r_issued;
    logic                   r_aborted;
    logic [OPCODE_BITS-1:0] r_op;
    logic [ADDR_BITS-1:0]   r_acc_a;
    logic [ADDR_BITS-1:0]   r_acc_b;
    logic [ADDR_BITS-1:0]   r_str_a;
    logic [ADDR_BITS-1:0]   r_str_b;
    logic [CNT_BITS-1:0]    r_cnt;
    logic [CNT_BITS-1:0]    r_iter;
    logic                   r_sync;
    logic                   r_last;

    logic [DESC_BITS-1:0]   w_rd;
    logic [OPCODE_BITS-1:0] w_rd_op;
    logic [ADDR_BITS-1:0]   w_rd_ab;
    logic [ADDR_BITS-1:0]   w_rd_as;
    logic [ADDR_BITS-1:0]   w_rd_bb;
    logic [ADDR_BITS-1:0]   w_rd_bs;
    logic [CNT_BITS-1:0]    w_rd_cnt;
    logic                   w_rd_sync;
    logic                   w_rd_last;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_last_slot;
    logic [CNT_BITS-1:0]    w_iter_inc;
    state_t                 w_desc_exit;

    assign w_rd        = r_table[r_cur_desc];
    assign w_rd_op     = w_rd[OFF_OP +: OPCODE_BITS];
    assign w_rd_ab     = w_rd[OFF_AB +: ADDR_BITS];
    assign w_rd_as     = w_rd[OFF_AS +: ADDR_BITS];
    assign w_rd_bb     = w_rd[OFF_BB +: ADDR_BITS];
    assign w_rd_bs     = w_rd[OFF_BS +: ADDR_BITS];
    assign w_rd_cnt    = w_rd[OFF_CNT +: CNT_BITS];
    assign w_rd_sync   = w_rd[1];
    assign w_rd_last   = w_rd[0];
    assign w_rise      = flag & ~r_flag_q;
    assign w_fall      = ~flag & r_flag_q;
    assign w_last_slot = (r_cur_desc == IDX_BITS'(NUM_DESC - 1));
    assign w_iter_inc  = r_iter + 1'b1;
    assign w_desc_exit = (r_last || w_last_slot) ? S_DRAIN_ISSUE : S_LOAD;

    // Table is writable only while no program is running
    always_ff @(posedge clk) begin
        if (desc_wr_en && r_state == S_IDLE)
            r_table[desc_wr_idx] <= desc_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort)
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort)
                    w_next = S_DRAIN_ISSUE;
                else if (w_rd_cnt == '0)
                    w_next = (w_rd_last || w_last_slot) ? S_DRAIN_ISSUE : S_LOAD;
                else
                    w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort)
                    w_next = S_DRAIN_ISSUE;
                else if (w_rise)
                    w_next = S_ACK;
            end
            S_ACK: begin
                if (w_fall) begin
                    if (r_aborted || abort)
                        w_next = S_DRAIN_ISSUE;
                    else if (w_iter_inc == r_cnt)
                        w_next = w_desc_exit;
                    else if (r_sync && r_iter == '0)
                        w_next = S_SYNC;
                    else
                        w_next = S_ISSUE;
                end
            end
            S_SYNC: begin
                if (abort)
                    w_next = S_DRAIN_ISSUE;
                else if (!idle_flag)
                    w_next = (r_iter == r_cnt) ? w_desc_exit : S_ISSUE;
            end
            S_DRAIN_ISSUE: begin
                if (w_rise)
                    w_next = S_DRAIN_ACK;
            end
            S_DRAIN_ACK: begin
                if (w_fall)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag_q   <= 1'b0;
            r_cur_desc <= '0;
            r_issued   <= '0;
            r_aborted  <= 1'b0;
            r_op       <= '0;
            r_acc_a    <= '0;
            r_acc_b    <= '0;
            r_str_a    <= '0;
            r_str_b    <= '0;
            r_cnt      <= '0;
            r_iter     <= '0;
            r_sync     <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_flag_q <= flag;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_issued   <= '0;
                        r_cur_desc <= '0;
                        r_aborted  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!abort) begin
                        r_op    <= w_rd_op;
                        r_acc_a <= w_rd_ab;
                        r_acc_b <= w_rd_bb;
                        r_str_a <= w_rd_as;
                        r_str_b <= w_rd_bs;
                        r_cnt   <= w_rd_cnt;
                        r_sync  <= w_rd_sync;
                        r_last  <= w_rd_last;
                        r_iter  <= '0;
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        r_issued <= (&r_issued) ? r_issued : r_issued + 1'b1;
                        r_acc_a  <= r_acc_a + r_str_a;
                        r_acc_b  <= r_acc_b + r_str_b;
                        r_iter   <= w_iter_inc;
                    end
                end
                S_DRAIN_ACK: begin
                    if (w_fall)
                        r_issued <= (&r_issued) ? r_issued : r_issued + 1'b1;
                end
                default: ;
            endcase
            if (w_next == S_LOAD && r_state != S_IDLE)
                r_cur_desc <= r_cur_desc + 1'b1;
            // In ACK this also serves as the pending-abort marker
            if (abort && (r_state inside {S_LOAD, S_ISSUE, S_ACK, S_SYNC}))
                r_aborted <= 1'b1;
        end
    end

    always_comb begin
        instruction = {OPCODE_BITS'(IDLE_OPCODE), {(2*ADDR_BITS){1'b0}}};
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        if (r_state == S_ISSUE || r_state == S_ACK)
            instruction = {r_op, r_acc_a, r_acc_b};
    end

    assign aborted    = r_aborted;
    assign cur_desc   = r_cur_desc;
    assign issued_cnt = r_issued;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: programs descriptors, answers
// handshakes with a toggling flag and checks issued instruction streams.
`timescale 1ns/1ps
module tb_inst_sequencer;

    localparam int OB = 4;
    localparam int AB = 16;
    localparam int CB = 10;
    localparam int IB = 4;
    localparam int DW = OB + 4*AB + CB + 2;
    localparam int IW = OB + 2*AB;

    logic          clk = 1'b0;
    logic          reset;
    logic          desc_wr_en;
    logic [IB-1:0] desc_wr_idx;
    logic [DW-1:0] desc_wr_data;
    logic          start;
    logic          abort;
    logic          flag;
    logic          idle_flag;
    logic [IW-1:0] instruction;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [IB-1:0] cur_desc;
    logic [31:0]   issued_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [IW-1:0] recs[$];
    int            rec_cyc[$];
    bit            got_done;
    logic          d_aborted;
    logic [31:0]   d_cnt;
    logic [IB-1:0] d_cur;
    int            idle_fall_cyc;

    inst_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .desc_wr_en   (desc_wr_en),
        .desc_wr_idx  (desc_wr_idx),
        .desc_wr_data (desc_wr_data),
        .start        (start),
        .abort        (abort),
        .flag         (flag),
        .idle_flag    (idle_flag),
        .instruction  (instruction),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .cur_desc     (cur_desc),
        .issued_cnt   (issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(int op, int ab, int as, int bb,
                                         int bs, int cnt, bit sy, bit la);
        return {OB'(op), AB'(ab), AB'(as), AB'(bb), AB'(bs), CB'(cnt), sy, la};
    endfunction

    function automatic logic [IW-1:0] ins(int op, int a, int b);
        return {OB'(op), AB'(a), AB'(b)};
    endfunction

    function automatic logic [IW-1:0] rec(int k);
        if (k < recs.size())
            return recs[k];
        return 'x;
    endfunction

    task automatic wr_desc(input int idx, input logic [DW-1:0] d);
        @(negedge clk);
        desc_wr_en   = 1'b1;
        desc_wr_idx  = IB'(idx);
        desc_wr_data = d;
        @(negedge clk);
        desc_wr_en   = 1'b0;
    endtask

    // Starts a program and plays the array: flag toggles every cycle,
    // each bump of issued_cnt logs the instruction held one cycle earlier.
    task automatic run_prog(input int max_cyc, input bit do_abort,
                            input bit hold);
        logic [IW-1:0] prev_instr;
        logic [31:0]   prev_cnt;
        int            hold_cnt;
        bit            ab_done;
        recs.delete();
        rec_cyc.delete();
        got_done      = 0;
        idle_fall_cyc = -1;
        hold_cnt      = 0;
        ab_done       = 0;
        prev_cnt      = '0;
        @(negedge clk);
        flag      = 1'b0;
        idle_flag = hold;
        start     = 1'b1;
        prev_instr = instruction;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (issued_cnt == prev_cnt + 1) begin
                recs.push_back(prev_instr);
                rec_cyc.push_back(i);
            end
            prev_cnt   = issued_cnt;
            prev_instr = instruction;
            if (done) begin
                got_done  = 1;
                d_aborted = aborted;
                d_cnt     = issued_cnt;
                d_cur     = cur_desc;
                break;
            end
            if (hold && recs.size() >= 1 && idle_flag) begin
                hold_cnt++;
                if (hold_cnt >= 20) begin
                    idle_flag     = 1'b0;
                    idle_fall_cyc = i;
                end
            end
            if (do_abort && !ab_done && flag && issued_cnt == 2) begin
                abort   = 1'b1;
                ab_done = 1;
            end else begin
                abort = 1'b0;
                flag  = ~flag;
            end
        end
        abort     = 1'b0;
        idle_flag = 1'b0;
        n_checks++;
        if (!got_done)
            $display("FAIL run_timeout: done not seen within %0d cycles", max_cyc);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (instruction !== ins(0, 0, 0))
            $display("FAIL rst_instr: got %h want %h", instruction, ins(0, 0, 0));
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done);
        else n_pass++;
        n_checks++;
        if (aborted !== 1'b0) $display("FAIL rst_aborted: got %b want 0", aborted);
        else n_pass++;
        n_checks++;
        if (cur_desc !== '0) $display("FAIL rst_cur_desc: got %0d want 0", cur_desc);
        else n_pass++;
        n_checks++;
        if (issued_cnt !== '0) $display("FAIL rst_issued: got %0d want 0", issued_cnt);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_main_seq();
        int bad = 0;
        wr_desc(0, mk(3, 0, 1, 0, 4, 64, 1, 1));
        run_prog(1000, 0, 0);
        for (int i = 0; i < 64 && i < recs.size(); i++)
            if (recs[i] !== ins(3, i, 4*i)) bad++;
        n_checks++;
        if (recs.size() != 65 || bad != 0)
            $display("FAIL main_seq: got %0d instrs %0d wrong, want 65 instrs 0 wrong",
                     recs.size(), bad);
        else n_pass++;
        n_checks++;
        if (rec(64) !== ins(0, 0, 0))
            $display("FAIL main_drain: got %h want %h", rec(64), ins(0, 0, 0));
        else n_pass++;
        n_checks++;
        if (d_cnt !== 32'd65) $display("FAIL main_issued: got %0d want 65", d_cnt);
        else n_pass++;
        n_checks++;
        if (d_aborted !== 1'b0) $display("FAIL main_aborted: got %b want 0", d_aborted);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL main_after_done: busy %b done %b want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_skip_zero();
        wr_desc(0, mk(1, 5, 1, 5, 1, 0, 0, 0));
        wr_desc(1, mk(2, 'h10, 1, 'h20, 2, 2, 0, 1));
        run_prog(200, 0, 0);
        n_checks++;
        if (recs.size() != 3 || rec(0) !== ins(2, 'h10, 'h20) ||
            rec(1) !== ins(2, 'h11, 'h22) || rec(2) !== ins(0, 0, 0))
            $display("FAIL skip_seq: got n=%0d %h %h %h want 3 %h %h %h",
                     recs.size(), rec(0), rec(1), rec(2),
                     ins(2, 'h10, 'h20), ins(2, 'h11, 'h22), ins(0, 0, 0));
        else n_pass++;
        n_checks++;
        if (d_cur !== 4'd1) $display("FAIL skip_cur_desc: got %0d want 1", d_cur);
        else n_pass++;
        n_checks++;
        if (d_cnt !== 32'd3) $display("FAIL skip_issued: got %0d want 3", d_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        wr_desc(0, mk(4, 'hFFFE, 1, 'h0, 0, 4, 0, 1));
        run_prog(200, 0, 0);
        n_checks++;
        if (rec(0) !== ins(4, 'hFFFE, 0) || rec(1) !== ins(4, 'hFFFF, 0) ||
            rec(2) !== ins(4, 0, 0) || rec(3) !== ins(4, 1, 0))
            $display("FAIL wrap_seq: got %h %h %h %h want A=FFFE,FFFF,0000,0001",
                     rec(0), rec(1), rec(2), rec(3));
        else n_pass++;
        n_checks++;
        if (d_cnt !== 32'd5) $display("FAIL wrap_issued: got %0d want 5", d_cnt);
        else n_pass++;
    endtask

    task automatic test_sync_wait();
        wr_desc(0, mk(6, 0, 1, 'h80, 1, 3, 1, 1));
        run_prog(300, 0, 1);
        n_checks++;
        if (idle_fall_cyc < 0 || rec_cyc.size() < 2 || rec_cyc[1] <= idle_fall_cyc)
            $display("FAIL sync_wait: 2nd instr at cycle %0d, idle fell at %0d; want later",
                     (rec_cyc.size() > 1) ? rec_cyc[1] : -1, idle_fall_cyc);
        else n_pass++;
        n_checks++;
        if (recs.size() != 4 || rec(1) !== ins(6, 1, 'h81))
            $display("FAIL sync_seq: got n=%0d %h want 4 %h",
                     recs.size(), rec(1), ins(6, 1, 'h81));
        else n_pass++;
    endtask

    task automatic test_abort_ack();
        wr_desc(0, mk(7, 0, 1, 'h40, 'h10, 8, 0, 1));
        run_prog(300, 1, 0);
        n_checks++;
        if (d_aborted !== 1'b1) $display("FAIL abort_flag: got %b want 1", d_aborted);
        else n_pass++;
        n_checks++;
        if (d_cnt !== 32'd4) $display("FAIL abort_issued: got %0d want 4", d_cnt);
        else n_pass++;
        n_checks++;
        if (rec(2) !== ins(7, 2, 'h60) || rec(3) !== ins(0, 0, 0))
            $display("FAIL abort_seq: got %h %h want %h %h",
                     rec(2), rec(3), ins(7, 2, 'h60), ins(0, 0, 0));
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (aborted !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_hold: aborted %b busy %b want 1 0", aborted, busy);
        else n_pass++;
    endtask

    task automatic test_abort_start();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_start_busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (aborted !== 1'b1)
            $display("FAIL abort_start_kept: got %b want 1", aborted);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wr_desc(0, mk(5, 'h100, 1, 'h200, 2, 10, 0, 1));
        @(negedge clk);
        flag  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (issued_cnt == 3) break;
            flag = ~flag;
            @(negedge clk);
        end
        n_checks++;
        if (instruction !== ins(5, 'h103, 'h206))
            $display("FAIL mid_issue: got %h want %h", instruction, ins(5, 'h103, 'h206));
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (instruction !== ins(0, 0, 0) || busy !== 1'b0 || done !== 1'b0 ||
            aborted !== 1'b0 || cur_desc !== '0 || issued_cnt !== '0)
            $display("FAIL mid_reset: instr %h busy %b done %b ab %b cur %0d cnt %0d want all 0",
                     instruction, busy, done, aborted, cur_desc, issued_cnt);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        wr_desc(0, mk(5, 'h100, 1, 'h200, 2, 10, 0, 1));
        run_prog(300, 0, 0);
        n_checks++;
        if (rec(0) !== ins(5, 'h100, 'h200) || d_cnt !== 32'd11)
            $display("FAIL mid_restart: first %h cnt %0d want %h 11",
                     rec(0), d_cnt, ins(5, 'h100, 'h200));
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        desc_wr_en   = 1'b0;
        desc_wr_idx  = '0;
        desc_wr_data = '0;
        start        = 1'b0;
        abort        = 1'b0;
        flag         = 1'b0;
        idle_flag    = 1'b0;
        test_reset();
        test_main_seq();
        test_skip_zero();
        test_wrap();
        test_sync_wait();
        test_abort_ack();
        test_abort_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL provide parameter OPCODE_BITS, default 4, instruction opcode width.
REQ-002 SHALL provide parameter ADDR_BITS, default 16, width of each of ADDRA and ADDRB.
REQ-003 SHALL provide parameter CNT_BITS, default 10, per-descriptor repeat-count width.
REQ-004 SHALL provide parameter NUM_DESC, default 16 (power of 2, >=2), descriptor table depth.
REQ-005 SHALL provide parameter IDLE_OPCODE, default 0, opcode issued for the drain instruction.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, with ports `clk` and `reset`.
REQ-007 SHALL have port `clk`, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 SHALL have port `reset`, input, 1 bit, the asynchronous active-high reset.
REQ-009 SHALL have port `desc_wr_en`, input, 1 bit, the descriptor write strobe.
REQ-010 SHALL have port `desc_wr_idx`, input, clog2(NUM_DESC) bits, the descriptor slot.
REQ-011 SHALL have port `desc_wr_data`, input, DESC_BITS = OPCODE_BITS+4*ADDR_BITS+CNT_BITS+2 bits, packed from MSB as {opcode, addra_base, addra_stride, addrb_base, addrb_stride, count, sync, last}.
REQ-012 SHALL have port `start`, input, 1 bit, the program start pulse.
REQ-013 SHALL have port `abort`, input, 1 bit, the program abort request.
REQ-014 SHALL have port `flag`, input, 1 bit, the array handshake; the array raises it, then lowers it, once per accepted instruction.
REQ-015 SHALL have port `idle_flag`, input, 1 bit, high while the array is idle.
REQ-016 SHALL have port `instruction`, output, OPCODE_BITS+2*ADDR_BITS bits, packed from MSB as {opcode, ADDRA, ADDRB}.
REQ-017 SHALL have port `busy`, output, 1 bit, high while a program is running.
REQ-018 SHALL have ports `done` and `aborted`, outputs, 1 bit each; `done` pulses one cycle at program end, and `aborted` qualifies `done`.
REQ-019 SHALL have port `cur_desc`, output, clog2(NUM_DESC) bits, the active descriptor index.
REQ-020 SHALL have port `issued_cnt`, output, 32 bits, the saturating count of completed handshakes in the current program.

Function
REQ-021 SHALL implement states IDLE, LOAD, ISSUE, ACK, SYNC, DRAIN_ISSUE, DRAIN_ACK and DONE.
REQ-022 SHALL write a descriptor on `desc_wr_en` only in IDLE; writes in other states are ignored.
REQ-023 SHALL, on `start` in IDLE, clear `issued_cnt` and set `cur_desc` to 0, with `busy`=1 from the next cycle; `start` outside IDLE is ignored.
REQ-024 SHALL, in LOAD (1 cycle), latch the descriptor, zero the iteration counter, load the address accumulators with the bases, and go to ISSUE, or skip to the next descriptor if count=0.
REQ-025 SHALL drive `instruction` = {opcode, accA, accB} in ISSUE and ACK, and {IDLE_OPCODE, 0, 0} in all other states.
REQ-026 SHALL detect a `flag` rising edge by comparing with a 1-cycle registered copy; in ISSUE, a rising edge moves the FSM to ACK.
REQ-027 SHALL, in ACK, on a `flag` falling edge: increment `issued_cnt` (saturate at 2^32-1); add the strides to accA/accB modulo 2^ADDR_BITS; increment the iteration counter.
REQ-028 SHALL, after the first handshake of a descriptor whose sync=1, enter SYNC and wait until `idle_flag`=0 before continuing.
REQ-029 SHALL, when iterations equal count, end the descriptor: if last=1 or cur_desc=NUM_DESC-1 go to DRAIN_ISSUE, else increment `cur_desc` and go to LOAD.
REQ-030 SHALL complete one full flag handshake on the IDLE instruction in DRAIN_ISSUE/DRAIN_ACK, then go to DONE.
REQ-031 SHALL, in DONE, pulse `done`=1 for one cycle, then return to IDLE with `busy`=0.
REQ-032 SHALL, on `abort` in LOAD, ISSUE or SYNC, go directly to DRAIN_ISSUE with `aborted` set.
REQ-033 SHALL, on `abort` in ACK, finish the current handshake first and then go to DRAIN_ISSUE; `aborted` is held until the next `start`.
REQ-034 SHALL, if `abort` and `start` coincide in IDLE, treat `start` as ignored.
REQ-035 SHALL accept a `flag` rising and falling edge no sooner than one cycle apart; back-to-back handshakes cost no extra cycles beyond the REQ-026/027 transitions.

Reset
REQ-036 SHALL, on `reset` asserted (asynchronous), set the state to IDLE and all outputs as follows: instruction={IDLE_OPCODE,0,0}, busy=0, done=0, aborted=0, cur_desc=0, issued_cnt=0.
REQ-037 SHALL leave descriptor table contents unspecified after reset, and SHALL take effect on `reset` asserted mid-program.

Verification
REQ-038 SHALL cover this case: desc0 = {op=3, aBase=0, aStride=1, bBase=0, bStride=4, count=64, sync=1, last=1} with a flag responder -> 64 instructions with ADDRA 0..63 and ADDRB 0,4,..,252, then one IDLE, then `done`, issued_cnt=65.
REQ-039 SHALL cover this case: desc0 count=0 with last=0, desc1 count=2 with last=1 -> desc0 is skipped, exactly 2 desc1 instructions plus IDLE are issued, and cur_desc=1 at `done`.
REQ-040 SHALL cover this case: aBase=0xFFFE, aStride=1, count=4 -> ADDRA sequence FFFE, FFFF, 0000, 0001.
REQ-041 SHALL cover this case: sync=1 with `idle_flag` held high for 20 cycles after the first handshake -> no second instruction appears until `idle_flag` falls.
REQ-042 SHALL cover this case: `abort` during ACK of the 3rd iteration -> the 3rd handshake completes, the IDLE drain follows, and `done`=1 with `aborted`=1 and issued_cnt=4.
REQ-043 SHALL cover this case: `reset` pulsed while in ISSUE -> all outputs return to reset values immediately, and a new `start` runs the program from desc0.
